vin_bt656_decoder: RTL



---
 rtl/vin_bt656_pkg.sv | 39 +++
 rtl/vin_bt656_trs_detect.sv | 60 ++++++
 rtl/vin_bt656_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/vin_bt656_pkg.sv
// rtl/vin_bt656_pkg.sv - shared encodings and XY helpers for the BT.656 decoder
package vin_bt656_pkg;

    typedef enum logic [1:0] {
        TRS_IDLE = 2'd0,
        TRS_FF   = 2'd1,
        TRS_00   = 2'd2,
        TRS_XY   = 2'd3
    } trs_state_t;

    typedef enum logic [1:0] {
        PH_CB = 2'd0,
        PH_Y0 = 2'd1,
        PH_CR = 2'd2,
        PH_Y1 = 2'd3
    } phase_t;

    localparam logic [7:0]  TRS_BYTE_FF = 8'hFF;
    localparam logic [7:0]  TRS_BYTE_00 = 8'h00;
    localparam logic [11:0] CNT_MAX     = 12'hFFF;

    localparam int XY_BIT_ONE = 7;
    localparam int XY_BIT_F   = 6;
    localparam int XY_BIT_V   = 5;
    localparam int XY_BIT_H   = 4;
    localparam int XY_BIT_P3  = 3;
    localparam int XY_BIT_P2  = 2;
    localparam int XY_BIT_P1  = 1;
    localparam int XY_BIT_P0  = 0;

    // Protection bits must match the F/V/H flags they cover
    function automatic logic xy_prot_ok(input logic [7:0] xy);
        return (xy[XY_BIT_P3] == (xy[XY_BIT_V] ^ xy[XY_BIT_H])) &&
               (xy[XY_BIT_P2] == (xy[XY_BIT_F] ^ xy[XY_BIT_H])) &&
               (xy[XY_BIT_P1] == (xy[XY_BIT_F] ^ xy[XY_BIT_V])) &&
               (xy[XY_BIT_P0] == (xy[XY_BIT_F] ^ xy[XY_BIT_V] ^ xy[XY_BIT_H]));
    endfunction

endpackage

// File: rtl/vin_bt656_trs_detect.sv
// rtl/vin_bt656_trs_detect.sv - TRS (FF 00 00 XY) tracker and XY decode; VIN_BT656_XY_CHECK_EN enables protection-bit check
module vin_bt656_trs_detect (
    input  logic       vin_clk,
    input  logic       rst_n,
    input  logic [7:0] d0,
    output logic       xy_valid,
    output logic       f,
    output logic       v,
    output logic       h,
    output logic       xy_err
);
    import vin_bt656_pkg::*;

    trs_state_t state;
    trs_state_t state_nxt;
    logic       xy_ok;

`ifdef VIN_BT656_XY_CHECK_EN
    assign xy_ok = d0[XY_BIT_ONE] && xy_prot_ok(d0);
`else
    assign xy_ok = d0[XY_BIT_ONE];
`endif

    assign f = d0[XY_BIT_F];
    assign v = d0[XY_BIT_V];
    assign h = d0[XY_BIT_H];

    // TRS state register
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) state <= TRS_IDLE;
        else        state <= state_nxt;
    end

    // Preamble matching; the byte after 00 00 is taken as XY and qualified
    always_comb begin
        state_nxt = TRS_IDLE;
        xy_valid  = 1'b0;
        xy_err    = 1'b0;
        case (state)
            TRS_IDLE: begin
                if (d0 == TRS_BYTE_FF) state_nxt = TRS_FF;
            end
            TRS_FF: begin
                if (d0 == TRS_BYTE_00)      state_nxt = TRS_00;
                else if (d0 == TRS_BYTE_FF) state_nxt = TRS_FF;
            end
            TRS_00: begin
                if (d0 == TRS_BYTE_00)      state_nxt = TRS_XY;
                else if (d0 == TRS_BYTE_FF) state_nxt = TRS_FF;
            end
            TRS_XY: begin
                if (d0 == TRS_BYTE_FF) state_nxt = TRS_FF;
                xy_valid = xy_ok;
                xy_err   = !xy_ok;
            end
            default: state_nxt = TRS_IDLE;
        endcase
    end

endmodule

// File: rtl/vin_bt656_decoder.sv
// rtl/vin_bt656_decoder.sv - BT.656 byte stream to YC pixel/timing decoder top; XY check via VIN_BT656_XY_CHECK_EN
module vin_bt656_decoder #(
    parameter logic [11:0] TRS_TIMEOUT = 12'd2048,
    parameter logic [1:0]  LOCK_LINES  = 2'd2
) (
    input  logic        vin_clk,
    input  logic        rst_n,
    input  logic [7:0]  bt656_data,
    output logic        vin_vs,
    output logic        vin_f,
    output logic        vin_de,
    output logic [15:0] vin_data,
    output logic [11:0] vin_width,
    output logic [11:0] vin_height,
    output logic        timing_locked,
    output logic        xy_err
);
    import vin_bt656_pkg::*;

    logic [7:0]  d0;
    logic        xy_valid, trs_f, trs_v, trs_h, xy_err_c;
    logic        active;
    phase_t      phase;
    logic [7:0]  c_lat;
    logic        pix_vld;
    logic [15:0] pix_data;
    logic [11:0] pix_cnt, line_cnt, to_cnt;
    logic [1:0]  match_cnt, match_inc;
    logic        is_ff, sav, line_end, to_hit, v_rise, data_byte, y_byte;

    vin_bt656_trs_detect u_trs (
        .vin_clk  (vin_clk),
        .rst_n    (rst_n),
        .d0       (d0),
        .xy_valid (xy_valid),
        .f        (trs_f),
        .v        (trs_v),
        .h        (trs_h),
        .xy_err   (xy_err_c)
    );

    assign is_ff     = (d0 == TRS_BYTE_FF);
    assign sav       = xy_valid && !trs_h && !trs_v;
    // A line closes on the first FF inside the active region or on EAV;
    // the pixel count is cleared at close so an EAV right after an FF does not latch twice.
    assign line_end  = (active && is_ff) || (xy_valid && trs_h);
    // A valid TRS on the same byte takes priority over the timeout
    assign to_hit    = (to_cnt >= TRS_TIMEOUT) && !xy_valid;
    assign v_rise    = xy_valid && trs_v && !vin_vs;
    assign data_byte = active && !is_ff && !to_hit;
    assign y_byte    = data_byte && ((phase == PH_Y0) || (phase == PH_Y1));
    assign match_inc = (match_cnt >= LOCK_LINES) ? LOCK_LINES : match_cnt + 2'd1;

    // Input capture stage
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) d0 <= 8'h00;
        else        d0 <= bt656_data;
    end

    // Bytes since the last valid TRS, saturating
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n)                to_cnt <= 12'd0;
        else if (xy_valid)         to_cnt <= 12'd0;
        else if (to_cnt != CNT_MAX) to_cnt <= to_cnt + 12'd1;
    end

    // Active-region flag and Cb/Y/Cr/Y byte phase
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            phase  <= PH_CB;
        end else if (sav) begin
            active <= 1'b1;
            phase  <= PH_CB;
        end else if (to_hit || (active && is_ff)) begin
            active <= 1'b0;
        end else if (active) begin
            phase  <= phase_t'(phase + 2'd1);
        end
    end

    // Chroma latch and pixel assembly stage
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            c_lat    <= 8'h00;
            pix_vld  <= 1'b0;
            pix_data <= 16'h0000;
        end else begin
            pix_vld <= y_byte;
            if (data_byte && !y_byte) c_lat <= d0;
            if (y_byte)               pix_data <= {d0, c_lat};
        end
    end

    // Active pixels in the current line
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n)                             pix_cnt <= 12'd0;
        else if (sav || line_end || to_hit)     pix_cnt <= 12'd0;
        else if (y_byte && pix_cnt != CNT_MAX)  pix_cnt <= pix_cnt + 12'd1;
    end

    // Width capture and lock on consecutive equal widths
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            vin_width     <= 12'd0;
            match_cnt     <= 2'd0;
            timing_locked <= 1'b0;
        end else if (to_hit) begin
            match_cnt     <= 2'd0;
            timing_locked <= 1'b0;
        end else if (line_end && pix_cnt != 12'd0) begin
            vin_width <= pix_cnt;
            if (pix_cnt == vin_width) begin
                match_cnt     <= match_inc;
                timing_locked <= (match_inc == LOCK_LINES);
            end else begin
                match_cnt     <= 2'd1;
                timing_locked <= 1'b0;
            end
        end
    end

    // Active-line count per field, captured when vertical blanking starts
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt   <= 12'd0;
            vin_height <= 12'd0;
        end else if (v_rise) begin
            vin_height <= line_cnt;
            line_cnt   <= 12'd0;
        end else if (sav && line_cnt != CNT_MAX) begin
            line_cnt   <= line_cnt + 12'd1;
        end
    end

    // Output registers for flags and pixel stream
    always_ff @(posedge vin_clk or negedge rst_n) begin
        if (!rst_n) begin
            vin_f    <= 1'b0;
            vin_vs   <= 1'b0;
            xy_err   <= 1'b0;
            vin_de   <= 1'b0;
            vin_data <= 16'h0000;
        end else begin
            if (xy_valid) begin
                vin_f  <= trs_f;
                vin_vs <= trs_v;
            end
            xy_err   <= xy_err_c;
            vin_de   <= pix_vld;
            vin_data <= pix_data;
        end
    end

endmodule
